// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter for a shared sync FIFO port.
// Bounded bursts per grant, zero-bubble handover between owners.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*DW-1:0]      req_data,
  output logic [N-1:0]         req_ready,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [DW-1:0]        fifo_wdata,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state, state_n;
  logic [IW-1:0] owner, owner_n;
  logic [IW-1:0] rr_ptr, rr_n;
  logic [CW-1:0] beat_cnt, cnt_n;

  logic [IW-1:0] succ;
  logic          own_valid;
  logic          xfer;
  logic          rel;
  logic [IW:0]   sel_idle;
  logic [IW:0]   sel_rel;

  // {found, index}: first valid requester scanning up from p, mod N
  function automatic logic [IW:0] pick(
    input logic [N-1:0]  v,
    input logic [IW-1:0] p
  );
    logic [IW:0] r;
    int          idx;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % N;
      if (v[idx]) r = {1'b1, IW'(idx)};
    end
    return r;
  endfunction

  assign succ      = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
  assign own_valid = req_valid[owner];
  assign xfer      = own_valid && !fifo_full;
  assign rel       = !own_valid ||
                     (xfer && beat_cnt == CW'(MAX_BURST - 1));
  assign sel_idle  = pick(req_valid, rr_ptr);
  assign sel_rel   = pick(req_valid, succ);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      rr_ptr   <= rr_n;
      beat_cnt <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n    = rr_ptr;
    cnt_n   = beat_cnt;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          state_n = OWN;
          owner_n = sel_idle[IW-1:0];
          cnt_n   = '0;
        end
      end
      OWN: begin
        if (rel) begin
          rr_n  = succ;
          cnt_n = '0;
          if (sel_rel[IW]) owner_n = sel_rel[IW-1:0];
          else             state_n = IDLE;
        end else if (xfer) begin
          cnt_n = beat_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // reset gates outputs combinationally so nothing leaks mid-reset
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_wdata = '0;
    grant_id   = '0;
    busy       = 1'b0;
    if (rst && state == OWN) begin
      busy             = 1'b1;
      grant_id         = owner;
      req_ready[owner] = !fifo_full;
      fifo_wr_en       = xfer;
      fifo_wdata       = req_data[int'(owner)*DW +: DW];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N=4, DW=8, MAX_BURST=4).
// Bench acts as producers and FIFO capture.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wdata;
  logic [1:0]  grant_id;
  logic        busy;

  fifo_wr_arbiter #(.N(4), .DW(8), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cnum     = 0;

  logic       vld [4];
  logic [7:0] val [4];
  int         left[4];

  logic [7:0] wq[$];
  logic [1:0] gq[$];
  int         cq[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]         = vld[i];
      req_data[i*8 +: 8]   = val[i];
    end
  endtask

  task automatic clear();
    for (int i = 0; i < 4; i++) begin
      vld[i]  = 1'b0;
      val[i]  = 8'(i * 16);
      left[i] = -1;
    end
    wq.delete();
    gq.delete();
    cq.delete();
  endtask

  // one clock: capture writes, advance accepted producers
  task automatic cyc();
    logic [3:0] acc;
    acc = req_valid & req_ready;
    if (fifo_wr_en) begin
      wq.push_back(fifo_wdata);
      gq.push_back(grant_id);
      cq.push_back(cnum);
    end
    @(posedge clk);
    #1;
    cnum++;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        val[i]++;
        if (left[i] > 0) begin
          left[i]--;
          if (left[i] == 0) vld[i] = 1'b0;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    fifo_full = 1'b0;
    clear();
    drive();
    cyc();
    cyc();
    rst = 1'b1;
    clear();
    cnum = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset with everyone requesting
    rst       = 1'b0;
    fifo_full = 1'b0;
    clear();
    for (int i = 0; i < 4; i++) vld[i] = 1'b1;
    drive();
    #1;
    for (int r = 0; r < 3; r++) begin
      chk("rst_wr_en", 32'(fifo_wr_en), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant", 32'(grant_id), 0);
      cyc();
    end
    rst = 1'b1;
    #1;
    chk("rst_bubble_busy", 32'(busy), 0);
    chk("rst_bubble_wr", 32'(fifo_wr_en), 0);
    cyc();
    chk("rst_first_busy", 32'(busy), 1);
    chk("rst_first_grant", 32'(grant_id), 0);
    chk("rst_first_wr", 32'(fifo_wr_en), 1);
    chk("rst_first_data", 32'(fifo_wdata), 32'h00);

    // single requester, 10 beats across burst boundaries
    do_reset();
    vld[2]  = 1'b1;
    left[2] = 10;
    val[2]  = 8'h20;
    drive();
    #1;
    chk("single_bubble", 32'(busy), 0);
    repeat (14) cyc();
    chk("single_count", 32'(wq.size()), 10);
    for (int k = 0; k < 10; k++) begin
      if (k < wq.size()) begin
        chk("single_data", 32'(wq[k]), 32'h20 + 32'(k));
        chk("single_grant", 32'(gq[k]), 2);
        chk("single_cycle", 32'(cq[k]), 32'(k + 1));
      end
    end
    chk("single_idle_end", 32'(busy), 0);

    // round robin among 0, 1, 3
    do_reset();
    vld[0] = 1'b1;
    vld[1] = 1'b1;
    vld[3] = 1'b1;
    drive();
    #1;
    repeat (25) cyc();
    chk("rr_count", 32'(wq.size()), 24);
    for (int k = 0; k < 24; k++) begin
      if (k < wq.size()) begin
        int g;
        int o;
        g = (k / 4) % 3;
        o = (g == 2) ? 3 : g;
        chk("rr_grant", 32'(gq[k]), 32'(o));
        chk("rr_data", 32'(wq[k]),
            32'(o * 16 + (k / 12) * 4 + (k % 4)));
        chk("rr_cycle", 32'(cq[k]), 32'(k + 1));
      end
    end

    // early release hands over to 3
    do_reset();
    vld[1]  = 1'b1;
    left[1] = 2;
    vld[3]  = 1'b1;
    drive();
    #1;
    chk("early_bubble", 32'(busy), 0);
    cyc();
    chk("early_g1", 32'(grant_id), 1);
    chk("early_d1", 32'(fifo_wdata), 32'h10);
    chk("early_w1", 32'(fifo_wr_en), 1);
    cyc();
    chk("early_d2", 32'(fifo_wdata), 32'h11);
    chk("early_w2", 32'(fifo_wr_en), 1);
    cyc();
    chk("early_drop_wr", 32'(fifo_wr_en), 0);
    chk("early_drop_busy", 32'(busy), 1);
    chk("early_drop_grant", 32'(grant_id), 1);
    cyc();
    chk("early_g3", 32'(grant_id), 3);
    chk("early_w3", 32'(fifo_wr_en), 1);
    chk("early_d3", 32'(fifo_wdata), 32'h30);
    chk("early_rr", 32'(dut.rr_ptr), 2);

    // full stall mid-burst
    do_reset();
    vld[0] = 1'b1;
    vld[2] = 1'b1;
    drive();
    #1;
    cyc();
    chk("full_b0", 32'(fifo_wdata), 32'h00);
    chk("full_w0", 32'(fifo_wr_en), 1);
    cyc();
    chk("full_b1", 32'(fifo_wdata), 32'h01);
    cyc();
    fifo_full = 1'b1;
    #1;
    for (int r = 0; r < 5; r++) begin
      chk("full_wr", 32'(fifo_wr_en), 0);
      chk("full_ready", 32'(req_ready), 0);
      chk("full_grant", 32'(grant_id), 0);
      chk("full_busy", 32'(busy), 1);
      chk("full_cnt", 32'(dut.beat_cnt), 2);
      cyc();
    end
    fifo_full = 1'b0;
    #1;
    chk("full_b2_wr", 32'(fifo_wr_en), 1);
    chk("full_b2", 32'(fifo_wdata), 32'h02);
    chk("full_b2_grant", 32'(grant_id), 0);
    cyc();
    chk("full_b3", 32'(fifo_wdata), 32'h03);
    cyc();
    chk("full_rot_grant", 32'(grant_id), 2);
    chk("full_rot_data", 32'(fifo_wdata), 32'h20);
    chk("full_rot_wr", 32'(fifo_wr_en), 1);

    // reset while owning req 1
    do_reset();
    vld[1] = 1'b1;
    drive();
    #1;
    repeat (5) cyc();
    chk("mid_grant", 32'(grant_id), 1);
    chk("mid_wr", 32'(fifo_wr_en), 1);
    chk("mid_data", 32'(fifo_wdata), 32'h14);
    vld[0] = 1'b1;
    vld[3] = 1'b1;
    rst    = 1'b0;
    drive();
    #1;
    chk("mid_rst_wr", 32'(fifo_wr_en), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_wdata", 32'(fifo_wdata), 0);
    cyc();
    chk("mid_rst_rr", 32'(dut.rr_ptr), 0);
    rst = 1'b1;
    #1;
    chk("mid_bubble", 32'(busy), 0);
    cyc();
    chk("mid_regrant", 32'(grant_id), 0);
    chk("mid_regrant_busy", 32'(busy), 1);
    chk("mid_regrant_data", 32'(fifo_wdata), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
